// File: rtl/noc_pkg.sv
// Shared NoC router definitions: channel IDs, flit width, one-hot port order and priority helpers.
package noc_pkg;

    localparam logic [2:0] LOCAL_CHANNEL_ID = 3'd0;
    localparam logic [2:0] NORTH_CHANNEL_ID = 3'd1;
    localparam logic [2:0] SOUTH_CHANNEL_ID = 3'd2;
    localparam logic [2:0] EAST_CHANNEL_ID  = 3'd3;
    localparam logic [2:0] WEST_CHANNEL_ID  = 3'd4;

    localparam int FLIT_W    = 18;
    localparam int NUM_PORTS = 5;

    // Bit positions inside every one-hot port vector {south, east, north, west, local}
    localparam logic [2:0] IDX_LOCAL = 3'd0;
    localparam logic [2:0] IDX_WEST  = 3'd1;
    localparam logic [2:0] IDX_NORTH = 3'd2;
    localparam logic [2:0] IDX_EAST  = 3'd3;
    localparam logic [2:0] IDX_SOUTH = 3'd4;

    // First set bit of req scanning upward from index start, wrapping after south.
    function automatic logic [4:0] pick_first(input logic [4:0] req, input logic [2:0] start);
        logic [4:0] sel;
        logic       found;
        logic [2:0] idx;
        sel   = 5'b00000;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = 3'((int'(start) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // Index following the single set bit of a one-hot vector, wrapping south -> local.
    function automatic logic [2:0] next_after(input logic [4:0] onehot);
        logic [2:0] nxt;
        nxt = IDX_LOCAL;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (onehot[i]) begin
                nxt = 3'((i + 1) % NUM_PORTS);
            end else begin
                nxt = nxt;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/noc_port_arbiter.sv
// Single-output grant register: urgent-first, then fixed (or, with PORT_SWITCH_ROUND_ROBIN_EN, rotating) priority.
module noc_port_arbiter
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] vreq,
    input  logic [4:0] urgent,
    input  logic       hs_idle,
    input  logic       tail_done,
    output logic [4:0] grant
);

    logic [4:0] grant_r;
    logic [4:0] grant_nxt_s;
    logic [2:0] ptr_s;
    logic       held_s;
    logic       release_s;

    // Next grant: issue only from idle, hold otherwise until the owner lets go or a tail flit completes.
    always_comb begin
        held_s      = |(grant_r & vreq);
        release_s   = (grant_r != 5'b00000) && ((!held_s && hs_idle) || tail_done);
        grant_nxt_s = grant_r;
        if (grant_r == 5'b00000) begin
            if ((vreq & urgent) != 5'b00000) begin
                grant_nxt_s = pick_first(vreq & urgent, IDX_LOCAL);
            end else begin
                grant_nxt_s = pick_first(vreq, ptr_s);
            end
        end else if (release_s) begin
            grant_nxt_s = 5'b00000;
        end else begin
            grant_nxt_s = grant_r;
        end
    end

    // Grant register; an asynchronous reset drops ownership immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r <= 5'b00000;
        end else begin
            grant_r <= grant_nxt_s;
        end
    end

`ifdef PORT_SWITCH_ROUND_ROBIN_EN
    logic [2:0] ptr_r;

    // Rotate non-urgent priority to the input after the grantee that just released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= IDX_LOCAL;
        end else if (release_s) begin
            ptr_r <= next_after(grant_r);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = IDX_LOCAL;
`endif

    assign grant = grant_r;

endmodule

// File: rtl/noc_port_switch.sv
// One output direction of a 5-port mesh router: route match, arbitration and req/ack/flit crossbar slice.
// Optional rotating priority is enabled by defining PORT_SWITCH_ROUND_ROBIN_EN.
module noc_port_switch #(
    parameter logic [2:0] PORT_ID = 3'b000,
    parameter int         FLIT_W  = noc_pkg::FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_port_local,
    input  logic              req_port_west,
    input  logic              req_port_north,
    input  logic              req_port_east,
    input  logic              req_port_south,
    input  logic [2:0]        rout_port_local,
    input  logic [2:0]        rout_port_west,
    input  logic [2:0]        rout_port_north,
    input  logic [2:0]        rout_port_east,
    input  logic [2:0]        rout_port_south,
    output logic              grant_local,
    output logic              grant_west,
    output logic              grant_north,
    output logic              grant_east,
    output logic              grant_south,
    input  logic              req_out_local,
    input  logic              req_out_west,
    input  logic              req_out_north,
    input  logic              req_out_east,
    input  logic              req_out_south,
    input  logic [FLIT_W-1:0] data_out_local,
    input  logic [FLIT_W-1:0] data_out_west,
    input  logic [FLIT_W-1:0] data_out_north,
    input  logic [FLIT_W-1:0] data_out_east,
    input  logic [FLIT_W-1:0] data_out_south,
    output logic              ack_out_local,
    output logic              ack_out_west,
    output logic              ack_out_north,
    output logic              ack_out_east,
    output logic              ack_out_south,
    input  logic              ack_out_port,
    output logic              req_out_port,
    output logic [FLIT_W-1:0] data_out_port,
    input  logic              tail_local,
    input  logic              tail_west,
    input  logic              tail_north,
    input  logic              tail_east,
    input  logic              tail_south,
    input  logic              urgent_local,
    input  logic              urgent_west,
    input  logic              urgent_north,
    input  logic              urgent_east,
    input  logic              urgent_south
);
    import noc_pkg::*;

    logic [4:0]        req_port_s;
    logic [4:0]        req_flit_s;
    logic [4:0]        tail_s;
    logic [4:0]        urgent_s;
    logic [4:0]        vreq_s;
    logic [4:0]        grant_s;
    logic [4:0]        ack_vec_s;
    logic [2:0]        rout_s [NUM_PORTS];
    logic [FLIT_W-1:0] data_s [NUM_PORTS];
    logic [FLIT_W-1:0] data_fwd_s;
    logic              req_fwd_s;
    logic              hs_idle_s;
    logic              tail_done_s;
    logic              ack_phase_r;
    logic              tail_lat_r;

    assign req_port_s = {req_port_south, req_port_east, req_port_north, req_port_west, req_port_local};
    assign req_flit_s = {req_out_south, req_out_east, req_out_north, req_out_west, req_out_local};
    assign tail_s     = {tail_south, tail_east, tail_north, tail_west, tail_local};
    assign urgent_s   = {urgent_south, urgent_east, urgent_north, urgent_west, urgent_local};
    assign rout_s     = '{rout_port_local, rout_port_west, rout_port_north, rout_port_east, rout_port_south};
    assign data_s     = '{data_out_local, data_out_west, data_out_north, data_out_east, data_out_south};

    // Route match plus crossbar; everything is gated by the grant so a dropped grant silences the link at once.
    always_comb begin
        data_fwd_s = {FLIT_W{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            vreq_s[i]  = req_port_s[i] & (rout_s[i] == PORT_ID);
            data_fwd_s = data_fwd_s | (data_s[i] & {FLIT_W{grant_s[i]}});
        end
        req_fwd_s   = |(req_flit_s & grant_s);
        ack_vec_s   = grant_s & {NUM_PORTS{ack_out_port}};
        hs_idle_s   = !req_fwd_s && !ack_out_port;
        tail_done_s = ack_phase_r && tail_lat_r && hs_idle_s;
    end

    // Track the ack-high phase and remember whether the flit accepted in it was a tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_phase_r <= 1'b0;
            tail_lat_r  <= 1'b0;
        end else if (grant_s == 5'b00000) begin
            ack_phase_r <= 1'b0;
            tail_lat_r  <= 1'b0;
        end else if (req_fwd_s && ack_out_port) begin
            ack_phase_r <= 1'b1;
            tail_lat_r  <= |(tail_s & grant_s);
        end else if (hs_idle_s) begin
            ack_phase_r <= 1'b0;
            tail_lat_r  <= 1'b0;
        end else begin
            ack_phase_r <= ack_phase_r;
            tail_lat_r  <= tail_lat_r;
        end
    end

    noc_port_arbiter u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .vreq      (vreq_s),
        .urgent    (urgent_s),
        .hs_idle   (hs_idle_s),
        .tail_done (tail_done_s),
        .grant     (grant_s)
    );

    assign grant_local   = grant_s[IDX_LOCAL];
    assign grant_west    = grant_s[IDX_WEST];
    assign grant_north   = grant_s[IDX_NORTH];
    assign grant_east    = grant_s[IDX_EAST];
    assign grant_south   = grant_s[IDX_SOUTH];
    assign ack_out_local = ack_vec_s[IDX_LOCAL];
    assign ack_out_west  = ack_vec_s[IDX_WEST];
    assign ack_out_north = ack_vec_s[IDX_NORTH];
    assign ack_out_east  = ack_vec_s[IDX_EAST];
    assign ack_out_south = ack_vec_s[IDX_SOUTH];
    assign req_out_port  = req_fwd_s;
    assign data_out_port = data_fwd_s;

endmodule

// File: tb/tb_noc_port_switch.sv
// Directed self-checking bench for noc_port_switch configured as the SOUTH output.
module tb_noc_port_switch;

    logic        clk;
    logic        rst;
    logic [4:0]  req_port_v;
    logic [4:0]  req_out_v;
    logic [4:0]  tail_v;
    logic [4:0]  urgent_v;
    logic [2:0]  rout_v [5];
    logic [17:0] data_v [5];
    logic        ack_out_port;
    wire  [4:0]  grant_w;
    wire  [4:0]  ack_w;
    wire         req_out_port;
    wire  [17:0] data_out_port;

    int checks;
    int errors;

    noc_port_switch #(.PORT_ID(3'd2), .FLIT_W(18)) dut (
        .clk(clk), .rst(rst),
        .req_port_local(req_port_v[0]), .req_port_west(req_port_v[1]), .req_port_north(req_port_v[2]),
        .req_port_east(req_port_v[3]), .req_port_south(req_port_v[4]),
        .rout_port_local(rout_v[0]), .rout_port_west(rout_v[1]), .rout_port_north(rout_v[2]),
        .rout_port_east(rout_v[3]), .rout_port_south(rout_v[4]),
        .grant_local(grant_w[0]), .grant_west(grant_w[1]), .grant_north(grant_w[2]),
        .grant_east(grant_w[3]), .grant_south(grant_w[4]),
        .req_out_local(req_out_v[0]), .req_out_west(req_out_v[1]), .req_out_north(req_out_v[2]),
        .req_out_east(req_out_v[3]), .req_out_south(req_out_v[4]),
        .data_out_local(data_v[0]), .data_out_west(data_v[1]), .data_out_north(data_v[2]),
        .data_out_east(data_v[3]), .data_out_south(data_v[4]),
        .ack_out_local(ack_w[0]), .ack_out_west(ack_w[1]), .ack_out_north(ack_w[2]),
        .ack_out_east(ack_w[3]), .ack_out_south(ack_w[4]),
        .ack_out_port(ack_out_port), .req_out_port(req_out_port), .data_out_port(data_out_port),
        .tail_local(tail_v[0]), .tail_west(tail_v[1]), .tail_north(tail_v[2]),
        .tail_east(tail_v[3]), .tail_south(tail_v[4]),
        .urgent_local(urgent_v[0]), .urgent_west(urgent_v[1]), .urgent_north(urgent_v[2]),
        .urgent_east(urgent_v[3]), .urgent_south(urgent_v[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_g;
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        req_port_v   = 5'b11111;
        req_out_v    = 5'b00001;
        tail_v       = 5'b00000;
        urgent_v     = 5'b00000;
        ack_out_port = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rout_v[i] = 3'd2;
            data_v[i] = 18'h2A5A5 ^ 18'(i);
        end

        // Reset holds everything low even with requests and ack present
        step();
        step();
        chk("reset_grant", 32'(grant_w), 32'h0);
        chk("reset_req_out", 32'(req_out_port), 32'h0);
        chk("reset_data", 32'(data_out_port), 32'h0);
        chk("reset_ack", 32'(ack_w), 32'h0);

        req_out_v    = 5'b00000;
        ack_out_port = 1'b0;
        rst          = 1'b1;
        #1;
        chk("grant_before_edge", 32'(grant_w), 32'h0);
        step();
        chk("first_grant_local", 32'(grant_w), 32'h01);

        // Local flit forwarded; west's flit request must be ignored
        data_v[0] = 18'h2A5A5;
        data_v[1] = 18'h11111;
        req_out_v = 5'b00011;
        #1;
        chk("fwd_req", 32'(req_out_port), 32'h1);
        chk("fwd_data", 32'(data_out_port), 32'h2A5A5);
        ack_out_port = 1'b1;
        #1;
        chk("fwd_ack", 32'(ack_w), 32'h01);
        step();
        req_out_v    = 5'b00000;
        ack_out_port = 1'b0;
        step();
        chk("hold_after_hs", 32'(grant_w), 32'h01);

        // Drain: each release takes one edge to IDLE, the next grant one more edge
        req_port_v[0] = 1'b0;
        for (int k = 1; k < 5; k++) begin
            exp_g = 5'b00001 << k;
            step();
            chk("release_idle", 32'(grant_w), 32'h0);
            step();
            chk("drain_grant", 32'(grant_w), 32'(exp_g));
            data_v[k]    = 18'h30000 | 18'(k * 18'h111);
            req_out_v[k] = 1'b1;
            #1;
            chk("drain_data", 32'(data_out_port), 32'(18'h30000 | 18'(k * 18'h111)));
            ack_out_port = 1'b1;
            #1;
            chk("drain_ack", 32'(ack_w), 32'(exp_g));
            step();
            req_out_v[k] = 1'b0;
            ack_out_port = 1'b0;
            step();
            req_port_v[k] = 1'b0;
        end
        step();
        chk("drain_done", 32'(grant_w), 32'h0);

        // Requests routed elsewhere never get this output
        req_port_v = 5'b11111;
        for (int i = 0; i < 5; i++) rout_v[i] = 3'(i == 2 ? 0 : i);
        step();
        step();
        chk("wrong_route_grant", 32'(grant_w), 32'h0);
        req_out_v    = 5'b00001;
        ack_out_port = 1'b1;
        #1;
        chk("wrong_route_req", 32'(req_out_port), 32'h0);
        chk("wrong_route_data", 32'(data_out_port), 32'h0);
        chk("wrong_route_ack", 32'(ack_w), 32'h0);
        req_out_v    = 5'b00000;
        ack_out_port = 1'b0;
        req_port_v   = 5'b00000;
        for (int i = 0; i < 5; i++) rout_v[i] = 3'd2;

        // Urgent east beats local from idle
        req_port_v = 5'b01001;
        urgent_v   = 5'b01000;
        step();
        chk("urgent_grant", 32'(grant_w), 32'h08);
        req_port_v[3] = 1'b0;
        urgent_v      = 5'b00000;
        step();
        chk("urgent_release", 32'(grant_w), 32'h0);
        step();
        chk("local_after_urgent", 32'(grant_w), 32'h01);

        // Urgent arrival must not preempt the local owner
        req_port_v[3] = 1'b1;
        urgent_v      = 5'b01000;
        step();
        step();
        chk("no_preempt", 32'(grant_w), 32'h01);
        req_port_v[3] = 1'b0;
        urgent_v      = 5'b00000;

        // Tail flit completion releases although local still requests
        tail_v[0]    = 1'b1;
        req_out_v[0] = 1'b1;
        ack_out_port = 1'b1;
        step();
        chk("tail_mid_hs", 32'(grant_w), 32'h01);
        req_out_v[0] = 1'b0;
        ack_out_port = 1'b0;
        step();
        chk("tail_release", 32'(grant_w), 32'h0);
        tail_v[0] = 1'b0;
        step();
        chk("tail_rearb", 32'(grant_w), 32'h01);

        // Reset mid-handshake silences the link immediately
        req_out_v[0] = 1'b1;
        ack_out_port = 1'b1;
        #1;
        chk("pre_reset_ack", 32'(ack_w), 32'h01);
        rst = 1'b0;
        #1;
        chk("async_grant", 32'(grant_w), 32'h0);
        chk("async_req", 32'(req_out_port), 32'h0);
        chk("async_ack", 32'(ack_w), 32'h0);
        chk("async_data", 32'(data_out_port), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
